frame_decode_words: RTL
=======================

# frame_decode_words

Parametrised successor to the ISO/IEC 14443A bit-level frame decoder. It sits between the PCD→PICC bit decoder (rx bit interface, one bit per `data_valid` strobe) and the initialisation/ISO14443-4 layers. It does the following:
- checks and strips per-word parity;
- packs data LSB-first into words of `WORD_BITS` bits with a valid-bit count;
- reports frame errors, including parity, missing final parity, zero-length frames and upstream errors;
- optionally records the index of the first failing word.

## Interface
- `WORD_BITS`, 8, data bits per parity-protected word (≥2).
- `MAX_WORDS`, 64, maximum words per frame; sets the width of the error index counter.
- `clk` in 1: sole clock.
- `rst_n` in 1: synchronous, active-low reset.
- `parity_en` in 1: 1 = a parity bit follows every full word; 0 = raw words. Sampled on `in_soc`.
- `odd_parity` in 1: 1 = odd parity (ISO14443A), 0 = even. Sampled on `in_soc`.
- `in_soc`, `in_eoc`, `in_data`, `in_data_valid`, `in_error` in 1 each: upstream bit stream.
- `out_soc` out 1: start-of-frame pulse.
- `out_eoc` out 1: end-of-frame pulse.
- `out_data` out `WORD_BITS`: packed word; bit 0 is the first received bit.
- `out_data_valid` out 1: one-cycle strobe for `out_data`.
- `out_data_bits` out `$clog2(WORD_BITS+1)`: number of valid bits in `out_data`.
- `out_error` out 1: frame error, valid while `out_eoc`=1.
- `last_bit` out 1: last bit received in the frame, whether data or parity.

## Operation
- State machine:
  - IDLE: wait for `in_soc`.
  - DATA: accumulate bits.
  - PARITY: expect a parity bit.
  - DROP: error seen; discard bits until `in_eoc`.
- IDLE → DATA on `in_soc`: pulse `out_soc`, clear the word shift register, bit counter, sticky error and word index, and latch `parity_en`/`odd_parity`.
- In DATA, each `in_data_valid` shifts `in_data` into bit position [count].
  - At count = `WORD_BITS`: go to PARITY if `parity_en`=1; otherwise emit the word with `out_data_bits`=`WORD_BITS` and stay in DATA.
- In PARITY, the next bit is compared to the XOR of the word, inverted for odd parity.
  - Match: emit the word (`out_data_bits`=`WORD_BITS`) and return to DATA.
  - Mismatch: set sticky error, record the word index, go to DROP. The failing word is not emitted.
- `in_eoc` in DATA with count 1..`WORD_BITS`-1: emit the partial word, with unused upper bits 0 and `out_data_bits`=count. The partial word carries no parity.
- `in_eoc` in DATA with count 0 after at least one word: no error.
- `in_eoc` in PARITY (final parity missing): error.
- `in_eoc` with no data bits at all: error.
- `in_error`=1 in any non-IDLE state: sticky error, then DROP.
- Once in DROP, no further `out_data_valid` is issued for the frame.
- `in_soc` while not IDLE: abandon the current frame (no `out_eoc`) and restart as on a fresh `in_soc`.
- `last_bit` updates on every accepted `in_data_valid`, including in DROP. It is stable from `out_eoc` until the next `in_data_valid` after `out_soc`.

## Timing
- Every output is registered, with a latency of one cycle from the input event: `out_soc` one cycle after `in_soc`; a word strobe one cycle after its last data bit or parity bit; `out_eoc` one cycle after `in_eoc`.
- The final partial word's `out_data_valid` and `out_eoc` assert in the same cycle.
- `out_error` is held 0 except while `out_eoc`=1.
- `in_data_valid` and `in_eoc` in the same cycle: process the bit first, then end the frame.
- Reset values (`rst_n`=0 for one `clk` edge): state IDLE and all outputs 0, including `last_bit`, `out_data` and `out_data_bits`.
- Reset mid-frame aborts silently, with no `out_eoc`.
- The word index saturates at `MAX_WORDS`-1.

## Configuration
- `FRAME_DECODE_ERR_INDEX_EN` defined: adds output `err_word_idx` [`$clog2(MAX_WORDS)`-1:0].
  - It holds the zero-based index of the word whose parity failed or whose parity was missing.
  - It equals the current word count for an `in_error`.
  - It is valid with `out_eoc` && `out_error`, is 0 otherwise, and resets to 0.
- Undefined: the port and its counter are absent. All other behaviour is identical.

## Structure
- Add the FSM state enum `FrameDecodeState` and the function `calc_parity(word, odd)` to `ISO14443A_pkg`.
- One sub-module, `word_packer`: LSB-first shift register with bit counter and clear, exposing `full` and `count`.

## Test plan
- `parity_en`=1, odd, 8 data bits 0xA5 + parity 1, then `in_eoc`:
  - one strobe with `out_data`=0xA5, `out_data_bits`=8;
  - then `out_eoc`, `out_error`=0, `last_bit`=1.
- Frame 0x3C,0x81 with the second parity flipped:
  - one strobe (0x3C);
  - `out_eoc` with `out_error`=1;
  - `err_word_idx`=1 when the macro is defined.
- 16 data bits with the final parity omitted: two words would complete, but only the first strobe occurs; `out_error`=1 on `out_eoc`.
- 7-bit frame 0x26 (REQA), `in_eoc`:
  - strobe with `out_data`=0x26, `out_data_bits`=7 in the same cycle as `out_eoc`;
  - `out_error`=0.
- `in_soc` immediately followed by `in_eoc`: `out_eoc` with `out_error`=1 and no strobes.
- Run with `WORD_BITS`=4 and `parity_en`=0:
  - 10 bits produce strobes of 4, 4 and 2 bits;
  - `rst_n` low mid-frame: all outputs 0 and no `out_eoc`.

Source files
------------

// File: rtl/ISO14443A_pkg.sv
// Shared types and helpers for the ISO14443A frame decoder.
// Holds the decoder FSM encoding and the word parity function.
package ISO14443A_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_DROP   = 2'd3
    } FrameDecodeState;

    // Expected parity bit for a zero-extended word (words up to 64 bits).
    function automatic logic calc_parity(input logic [63:0] word, input logic odd);
        return (^word) ^ odd;
    endfunction

endpackage

// File: rtl/word_packer.sv
// LSB-first shift register: bit i of the word is the i-th shifted bit.
// clr_i wins over shift_i; shifting stops once the word is full.
module word_packer #(
    parameter int W = 8,
    localparam int CW = $clog2(W + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_i,
    input  logic          shift_i,
    input  logic          bit_i,
    output logic [W-1:0]  data_o,
    output logic [CW-1:0] count_o,
    output logic          full_o
);

    logic [W-1:0]  data_q, data_d;
    logic [CW-1:0] count_q, count_d;

    assign full_o  = (count_q == CW'(W));
    assign data_o  = data_q;
    assign count_o = count_q;

    always_comb begin
        data_d  = data_q;
        count_d = count_q;
        if (clr_i) begin
            data_d  = '0;
            count_d = '0;
        end else if (shift_i && !full_o) begin
            data_d  = data_q | (W'(bit_i) << count_q);
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q  <= '0;
            count_q <= '0;
        end else begin
            data_q  <= data_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/frame_decode_words.sv
// ISO14443A bit-to-word frame decoder with per-word parity check.
// Define FRAME_DECODE_ERR_INDEX_EN to add the err_word_idx output.
module frame_decode_words
    import ISO14443A_pkg::*;
#(
    parameter int WORD_BITS = 8,
    parameter int MAX_WORDS = 64,
    localparam int BW = $clog2(WORD_BITS + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 parity_en,
    input  logic                 odd_parity,
    input  logic                 in_soc,
    input  logic                 in_eoc,
    input  logic                 in_data,
    input  logic                 in_data_valid,
    input  logic                 in_error,
    output logic                 out_soc,
    output logic                 out_eoc,
    output logic [WORD_BITS-1:0] out_data,
    output logic                 out_data_valid,
    output logic [BW-1:0]        out_data_bits,
    output logic                 out_error,
    output logic                 last_bit
`ifdef FRAME_DECODE_ERR_INDEX_EN
    ,
    output logic [$clog2(MAX_WORDS)-1:0] err_word_idx
`endif
);

    FrameDecodeState st_q, st_d;
    logic pe_q, pe_d, odd_q, odd_d;
    logic err_q, err_d, gw_q, gw_d;
    logic soc_q, soc_d, eoc_q, eoc_d, dv_q, dv_d;
    logic oerr_q, oerr_d, lb_q, lb_d;
    logic [WORD_BITS-1:0] data_q, data_d;
    logic [BW-1:0] bits_q, bits_d;

    logic pk_clr, pk_shift, pk_full;
    logic [WORD_BITS-1:0] pk_data;
    logic [BW-1:0] pk_count;

`ifdef FRAME_DECODE_ERR_INDEX_EN
    localparam int IW = $clog2(MAX_WORDS);
    logic [IW-1:0] widx_q, widx_d, eidx_q, eidx_d, oidx_q, oidx_d;
`endif

    word_packer #(.W(WORD_BITS)) u_pack (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (pk_clr),
        .shift_i (pk_shift),
        .bit_i   (in_data),
        .data_o  (pk_data),
        .count_o (pk_count),
        .full_o  (pk_full)
    );

    logic [WORD_BITS-1:0] word_nx, word_v;
    logic [BW-1:0] cnt_nx, cnt_v;
    FrameDecodeState st_v;
    logic bad;

    assign word_nx = pk_data | (WORD_BITS'(in_data) << pk_count);
    assign cnt_nx  = pk_count + 1'b1;

    always_comb begin
        st_d = st_q; pe_d = pe_q; odd_d = odd_q;
        err_d = err_q; gw_d = gw_q; lb_d = lb_q;
        soc_d = 1'b0; eoc_d = 1'b0; dv_d = 1'b0; oerr_d = 1'b0;
        data_d = data_q; bits_d = bits_q;
        pk_clr = 1'b0; pk_shift = 1'b0;
        word_v = pk_data; cnt_v = pk_count; st_v = st_q; bad = 1'b0;
`ifdef FRAME_DECODE_ERR_INDEX_EN
        widx_d = widx_q; eidx_d = eidx_q; oidx_d = '0;
`endif
        if (in_soc) begin
            st_d = ST_DATA; soc_d = 1'b1; pk_clr = 1'b1;
            err_d = 1'b0; gw_d = 1'b0;
            pe_d = parity_en; odd_d = odd_parity;
`ifdef FRAME_DECODE_ERR_INDEX_EN
            widx_d = '0; eidx_d = '0;
`endif
        end else if (st_q != ST_IDLE) begin
            if (in_data_valid) lb_d = in_data;
            if (in_error) begin
`ifdef FRAME_DECODE_ERR_INDEX_EN
                if (!err_q) eidx_d = widx_q;
`endif
                err_d = 1'b1; st_d = ST_DROP;
            end else if (in_data_valid) begin
                case (st_q)
                    ST_DATA: begin
                        pk_shift = 1'b1; word_v = word_nx; cnt_v = cnt_nx;
                        if (cnt_nx == BW'(WORD_BITS)) begin
                            if (pe_q) begin
                                st_d = ST_PARITY;
                            end else begin
                                dv_d = 1'b1; data_d = word_nx;
                                bits_d = BW'(WORD_BITS);
                                pk_clr = 1'b1; cnt_v = '0; gw_d = 1'b1;
`ifdef FRAME_DECODE_ERR_INDEX_EN
                                if (widx_q != IW'(MAX_WORDS - 1)) widx_d = widx_q + 1'b1;
`endif
                            end
                        end
                    end
                    ST_PARITY: begin
                        if (pk_full && in_data == calc_parity(64'(pk_data), odd_q)) begin
                            dv_d = 1'b1; data_d = pk_data;
                            bits_d = BW'(WORD_BITS);
                            pk_clr = 1'b1; cnt_v = '0; gw_d = 1'b1;
                            st_d = ST_DATA;
`ifdef FRAME_DECODE_ERR_INDEX_EN
                            if (widx_q != IW'(MAX_WORDS - 1)) widx_d = widx_q + 1'b1;
`endif
                        end else begin
`ifdef FRAME_DECODE_ERR_INDEX_EN
                            eidx_d = widx_q;
`endif
                            err_d = 1'b1; st_d = ST_DROP;
                        end
                    end
                    default: ;
                endcase
            end
            // End of frame is judged on the state after this cycle's bit.
            if (in_eoc) begin
                st_v = st_d;
                eoc_d = 1'b1; st_d = ST_IDLE; pk_clr = 1'b1;
                if (st_v == ST_DATA && cnt_v != '0) begin
                    dv_d = 1'b1; data_d = word_v; bits_d = cnt_v;
                end
                bad = err_d || st_v == ST_PARITY ||
                      (st_v == ST_DATA && cnt_v == '0 && !gw_d);
                oerr_d = bad;
`ifdef FRAME_DECODE_ERR_INDEX_EN
                if (bad) oidx_d = err_d ? eidx_d : widx_d;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st_q <= ST_IDLE; pe_q <= 1'b0; odd_q <= 1'b0;
            err_q <= 1'b0; gw_q <= 1'b0; lb_q <= 1'b0;
            soc_q <= 1'b0; eoc_q <= 1'b0; dv_q <= 1'b0; oerr_q <= 1'b0;
            data_q <= '0; bits_q <= '0;
`ifdef FRAME_DECODE_ERR_INDEX_EN
            widx_q <= '0; eidx_q <= '0; oidx_q <= '0;
`endif
        end else begin
            st_q <= st_d; pe_q <= pe_d; odd_q <= odd_d;
            err_q <= err_d; gw_q <= gw_d; lb_q <= lb_d;
            soc_q <= soc_d; eoc_q <= eoc_d; dv_q <= dv_d; oerr_q <= oerr_d;
            data_q <= data_d; bits_q <= bits_d;
`ifdef FRAME_DECODE_ERR_INDEX_EN
            widx_q <= widx_d; eidx_q <= eidx_d; oidx_q <= oidx_d;
`endif
        end
    end

    assign out_soc        = soc_q;
    assign out_eoc        = eoc_q;
    assign out_data       = data_q;
    assign out_data_valid = dv_q;
    assign out_data_bits  = bits_q;
    assign out_error      = oerr_q;
    assign last_bit       = lb_q;
`ifdef FRAME_DECODE_ERR_INDEX_EN
    assign err_word_idx   = oidx_q;
`endif

endmodule
